game_sequencer: RTL

Game-state controller for the dinosaur game. It owns dino_y, obstacle_x and game_over, which drive the pixel renderer.
- Runs the IDLE/RUN/OVER state machine, jump physics, obstacle scrolling, collision detection and scoring.
- All state advances only on frame_tick (vblank start), so renderer inputs stay constant across every active video frame.

---
 rtl/game_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: dino game state machine, jump physics, obstacle scroll, collision and score.
// Optional SPEEDUP_EN macro raises obstacle speed with score, capped at MAX_SPEED.
module game_sequencer #(
  parameter int SCREEN_W    = 640,
  parameter int GROUND_Y    = 400,
  parameter int DINO_X      = 64,
  parameter int DINO_W      = 40,
  parameter int DINO_H      = 43,
  parameter int OBS_W       = 24,
  parameter int OBS_H       = 48,
  parameter int JUMP_V      = 14,
  parameter int GRAVITY     = 1,
  parameter int SPEED       = 4,
`ifdef SPEEDUP_EN
  parameter int MAX_SPEED   = 12,
`endif
  parameter int HOLD_FRAMES = 30
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        jump_btn,
  output logic [11:0] dino_y,
  output logic [11:0] obstacle_x,
  output logic        game_over,
  output logic [15:0] score
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic signed [12:0] GND = 13'(GROUND_Y);
  logic [2:0] sync;
  logic jump_req, btn_edge;
  logic [1:0] state, state_n;
  logic [11:0] dino_y_n, obstacle_x_n, speed;
  logic [15:0] score_n;
  logic signed [8:0] vel, vel_n, vel_j;
  logic signed [12:0] new_y;
  logic airborne, airborne_n, game_over_n, hit;
  logic [HW-1:0] hold, hold_n;
  assign btn_edge = sync[1] & ~sync[2];
`ifdef SPEEDUP_EN
  logic [11:0] raw_speed;
  assign raw_speed = 12'(SPEED) + {5'd0, score[15:9]};
  assign speed = raw_speed > 12'(MAX_SPEED) ? 12'(MAX_SPEED) : raw_speed;
`else
  assign speed = 12'(SPEED);
`endif
  assign hit = (obstacle_x < 12'(DINO_X + DINO_W)) &&
               ({1'b0, obstacle_x} + 13'(OBS_W) > 13'(DINO_X)) &&
               ({1'b0, dino_y} + 13'(DINO_H) > 13'(GROUND_Y + DINO_H - OBS_H));
  // a jump launched this tick already moves the dino by JUMP_V
  assign vel_j = (!airborne && jump_req) ? 9'(JUMP_V) : vel;
  assign new_y = $signed({1'b0, dino_y}) - $signed({{4{vel_j[8]}}, vel_j});
  always_comb begin
    state_n      = state;
    dino_y_n     = dino_y;
    obstacle_x_n = obstacle_x;
    score_n      = score;
    vel_n        = vel;
    airborne_n   = airborne;
    game_over_n  = game_over;
    hold_n       = hold;
    if (frame_tick) begin
      if (state == S_IDLE) begin
        state_n = jump_req ? S_RUN : S_IDLE;
      end else if (state == S_RUN) begin
        if (hit) begin
          state_n     = S_OVER;
          game_over_n = 1'b1;
          hold_n      = '0;
        end else begin
          if (airborne || jump_req) begin
            airborne_n = new_y < GND;
            vel_n      = new_y >= GND ? 9'sd0 : vel_j - 9'(GRAVITY);
            dino_y_n   = new_y >= GND ? 12'(GROUND_Y) : new_y < 0 ? 12'd0 : new_y[11:0];
          end
          obstacle_x_n = obstacle_x < speed ? 12'(SCREEN_W) : obstacle_x - speed;
          score_n      = score == 16'hFFFF ? score : score + 16'd1;
        end
      end else begin
        hold_n = hold == HW'(HOLD_FRAMES) ? hold : hold + 1'b1;
        if (jump_req && hold == HW'(HOLD_FRAMES)) begin
          state_n      = S_RUN;
          dino_y_n     = 12'(GROUND_Y);
          obstacle_x_n = 12'(SCREEN_W);
          vel_n        = 9'sd0;
          airborne_n   = 1'b0;
          score_n      = '0;
          game_over_n  = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      jump_req   <= 1'b0;
      state      <= S_IDLE;
      dino_y     <= 12'(GROUND_Y);
      obstacle_x <= 12'(SCREEN_W);
      score      <= '0;
      vel        <= '0;
      airborne   <= 1'b0;
      game_over  <= 1'b0;
      hold       <= '0;
    end else begin
      sync       <= {sync[1:0], jump_btn};
      jump_req   <= frame_tick ? 1'b0 : (btn_edge | jump_req);
      state      <= state_n;
      dino_y     <= dino_y_n;
      obstacle_x <= obstacle_x_n;
      score      <= score_n;
      vel        <= vel_n;
      airborne   <= airborne_n;
      game_over  <= game_over_n;
      hold       <= hold_n;
    end
  end
endmodule
